mem_port_arbiter: RTL and testbench

- Two-requester round-robin arbiter sharing one memory-peripheral port, such as a register bank or RAM, using the standard req/res interface: addr, count, write flag, write data, read data and response code.
- Sits between the core's fetch and data load/store units and a single memory peripheral.
- Sequences each transfer: issue for one cycle, wait a fixed response latency, return the result to the granted requester with a one-cycle done pulse.

---
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of one memory peripheral port.
// Each transfer is issue (1 cycle), fixed-latency wait, then a one-cycle done pulse.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif
`ifndef MEM_CODE_INVALID
`define MEM_CODE_INVALID    2'd0
`define MEM_CODE_READ       2'd1
`define MEM_CODE_WRITE      2'd2
`define MEM_CODE_MISALIGNED 2'd3
`endif

module mem_port_arbiter #(
  parameter int unsigned RES_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [`ADDR_W-1:0]      i_req0_addr,
  input  logic [`MEM_COUNT_W-1:0] i_req0_count,
  input  logic                    i_req0_wr,
  input  logic [`WORD_W-1:0]      i_req0_wr_data,
  input  logic [`ADDR_W-1:0]      i_req1_addr,
  input  logic [`MEM_COUNT_W-1:0] i_req1_count,
  input  logic                    i_req1_wr,
  input  logic [`WORD_W-1:0]      i_req1_wr_data,
  output logic [`WORD_W-1:0]      o_res0_rd_data,
  output logic [`MEM_CODE_W-1:0]  o_res0_code,
  output logic                    o_res0_done,
  output logic [`WORD_W-1:0]      o_res1_rd_data,
  output logic [`MEM_CODE_W-1:0]  o_res1_code,
  output logic                    o_res1_done,
  output logic [`ADDR_W-1:0]      o_mem_req_addr,
  output logic [`MEM_COUNT_W-1:0] o_mem_req_count,
  output logic                    o_mem_req_wr,
  output logic [`WORD_W-1:0]      o_mem_req_wr_data,
  input  logic [`WORD_W-1:0]      i_mem_res_rd_data,
  input  logic [`MEM_CODE_W-1:0]  i_mem_res_code
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    req0_vld, req1_vld, any_req, pick;
  logic                    grant_q, last_grant_q;
  logic [3:0]              cnt_q;
  logic [`ADDR_W-1:0]      req_addr_q;
  logic [`MEM_COUNT_W-1:0] req_count_q;
  logic                    req_wr_q;
  logic [`WORD_W-1:0]      req_wr_data_q;
  logic [`WORD_W-1:0]      res0_rd_data_q, res1_rd_data_q;
  logic [`MEM_CODE_W-1:0]  res0_code_q, res1_code_q;
  logic                    res0_done_q, res1_done_q;

  assign req0_vld = (i_req0_count != `MEM_COUNT_NONE);
  assign req1_vld = (i_req1_count != `MEM_COUNT_NONE);
  assign any_req  = req0_vld | req1_vld;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req0_vld && req1_vld) pick = ~last_grant_q;
    else if (req1_vld)        pick = 1'b1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (any_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (cnt_q == 4'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req_count = `MEM_COUNT_NONE;
    if (state_q == ST_ISSUE) o_mem_req_count = req_count_q;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      grant_q        <= 1'b0;
      last_grant_q   <= 1'b1;
      cnt_q          <= 4'd0;
      req_addr_q     <= '0;
      req_count_q    <= `MEM_COUNT_NONE;
      req_wr_q       <= 1'b0;
      req_wr_data_q  <= '0;
      res0_rd_data_q <= '0;
      res0_code_q    <= `MEM_CODE_INVALID;
      res0_done_q    <= 1'b0;
      res1_rd_data_q <= '0;
      res1_code_q    <= `MEM_CODE_INVALID;
      res1_done_q    <= 1'b0;
    end else begin
      res0_done_q <= 1'b0;
      res1_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant_q       <= pick;
            req_addr_q    <= pick ? i_req1_addr    : i_req0_addr;
            req_count_q   <= pick ? i_req1_count   : i_req0_count;
            req_wr_q      <= pick ? i_req1_wr      : i_req0_wr;
            req_wr_data_q <= pick ? i_req1_wr_data : i_req0_wr_data;
          end
        end
        ST_ISSUE: cnt_q <= 4'(RES_LATENCY - 1);
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            if (grant_q) begin
              res1_rd_data_q <= i_mem_res_rd_data;
              res1_code_q    <= i_mem_res_code;
              res1_done_q    <= 1'b1;
            end else begin
              res0_rd_data_q <= i_mem_res_rd_data;
              res0_code_q    <= i_mem_res_code;
              res0_done_q    <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

  assign o_mem_req_addr    = req_addr_q;
  assign o_mem_req_wr      = req_wr_q;
  assign o_mem_req_wr_data = req_wr_data_q;
  assign o_res0_rd_data    = res0_rd_data_q;
  assign o_res0_code       = res0_code_q;
  assign o_res0_done       = res0_done_q;
  assign o_res1_rd_data    = res1_rd_data_q;
  assign o_res1_code       = res1_code_q;
  assign o_res1_done       = res1_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance a at RES_LATENCY=1, instance b at 3.
`timescale 1ns/1ps

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_COUNT_W
`define MEM_COUNT_W 2
`endif
`ifndef MEM_COUNT_NONE
`define MEM_COUNT_NONE 2'd0
`define MEM_COUNT_BYTE 2'd1
`define MEM_COUNT_HALF 2'd2
`define MEM_COUNT_WORD 2'd3
`endif
`ifndef MEM_CODE_W
`define MEM_CODE_W 2
`endif
`ifndef MEM_CODE_INVALID
`define MEM_CODE_INVALID    2'd0
`define MEM_CODE_READ       2'd1
`define MEM_CODE_WRITE      2'd2
`define MEM_CODE_MISALIGNED 2'd3
`endif

module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Instance a signals
  logic                    a_rstn;
  logic [`ADDR_W-1:0]      a_r0_addr, a_r1_addr;
  logic [`MEM_COUNT_W-1:0] a_r0_count, a_r1_count;
  logic                    a_r0_wr, a_r1_wr;
  logic [`WORD_W-1:0]      a_r0_wdat, a_r1_wdat;
  logic [`WORD_W-1:0]      a_s0_rdat, a_s1_rdat;
  logic [`MEM_CODE_W-1:0]  a_s0_code, a_s1_code;
  logic                    a_s0_done, a_s1_done;
  logic [`ADDR_W-1:0]      a_m_addr;
  logic [`MEM_COUNT_W-1:0] a_m_count;
  logic                    a_m_wr;
  logic [`WORD_W-1:0]      a_m_wdat;
  logic [`WORD_W-1:0]      a_p_rdat;
  logic [`MEM_CODE_W-1:0]  a_p_code;

  // Instance b signals
  logic                    b_rstn;
  logic [`ADDR_W-1:0]      b_r0_addr, b_r1_addr;
  logic [`MEM_COUNT_W-1:0] b_r0_count, b_r1_count;
  logic                    b_r0_wr, b_r1_wr;
  logic [`WORD_W-1:0]      b_r0_wdat, b_r1_wdat;
  logic [`WORD_W-1:0]      b_s0_rdat, b_s1_rdat;
  logic [`MEM_CODE_W-1:0]  b_s0_code, b_s1_code;
  logic                    b_s0_done, b_s1_done;
  logic [`ADDR_W-1:0]      b_m_addr;
  logic [`MEM_COUNT_W-1:0] b_m_count;
  logic                    b_m_wr;
  logic [`WORD_W-1:0]      b_m_wdat;
  logic [`WORD_W-1:0]      b_p_rdat;
  logic [`MEM_CODE_W-1:0]  b_p_code;

  mem_port_arbiter #(.RES_LATENCY(1)) dut_a (
    .clk(clk), .aresetn(a_rstn),
    .i_req0_addr(a_r0_addr), .i_req0_count(a_r0_count), .i_req0_wr(a_r0_wr), .i_req0_wr_data(a_r0_wdat),
    .i_req1_addr(a_r1_addr), .i_req1_count(a_r1_count), .i_req1_wr(a_r1_wr), .i_req1_wr_data(a_r1_wdat),
    .o_res0_rd_data(a_s0_rdat), .o_res0_code(a_s0_code), .o_res0_done(a_s0_done),
    .o_res1_rd_data(a_s1_rdat), .o_res1_code(a_s1_code), .o_res1_done(a_s1_done),
    .o_mem_req_addr(a_m_addr), .o_mem_req_count(a_m_count), .o_mem_req_wr(a_m_wr),
    .o_mem_req_wr_data(a_m_wdat),
    .i_mem_res_rd_data(a_p_rdat), .i_mem_res_code(a_p_code)
  );

  mem_port_arbiter #(.RES_LATENCY(3)) dut_b (
    .clk(clk), .aresetn(b_rstn),
    .i_req0_addr(b_r0_addr), .i_req0_count(b_r0_count), .i_req0_wr(b_r0_wr), .i_req0_wr_data(b_r0_wdat),
    .i_req1_addr(b_r1_addr), .i_req1_count(b_r1_count), .i_req1_wr(b_r1_wr), .i_req1_wr_data(b_r1_wdat),
    .o_res0_rd_data(b_s0_rdat), .o_res0_code(b_s0_code), .o_res0_done(b_s0_done),
    .o_res1_rd_data(b_s1_rdat), .o_res1_code(b_s1_code), .o_res1_done(b_s1_done),
    .o_mem_req_addr(b_m_addr), .o_mem_req_count(b_m_count), .o_mem_req_wr(b_m_wr),
    .o_mem_req_wr_data(b_m_wdat),
    .i_mem_res_rd_data(b_p_rdat), .i_mem_res_code(b_p_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rstn = 1'b0; b_rstn = 1'b0;
    a_r0_addr = '0; a_r0_count = `MEM_COUNT_NONE; a_r0_wr = 1'b0; a_r0_wdat = '0;
    a_r1_addr = '0; a_r1_count = `MEM_COUNT_NONE; a_r1_wr = 1'b0; a_r1_wdat = '0;
    b_r0_addr = '0; b_r0_count = `MEM_COUNT_NONE; b_r0_wr = 1'b0; b_r0_wdat = '0;
    b_r1_addr = '0; b_r1_count = `MEM_COUNT_NONE; b_r1_wr = 1'b0; b_r1_wdat = '0;
    a_p_rdat = '0; a_p_code = `MEM_CODE_INVALID;
    b_p_rdat = '0; b_p_code = `MEM_CODE_INVALID;
    tick(); tick();

    // Reset state
    chk("rst_count", 32'(a_m_count), 32'(`MEM_COUNT_NONE));
    chk("rst_addr", a_m_addr, 32'h0);
    chk("rst_wr", 32'(a_m_wr), 32'h0);
    chk("rst_res0_code", 32'(a_s0_code), 32'(`MEM_CODE_INVALID));
    chk("rst_res0_data", a_s0_rdat, 32'h0);
    chk("rst_res1_code", 32'(a_s1_code), 32'(`MEM_CODE_INVALID));
    chk("rst_done0", 32'(a_s0_done), 32'h0);
    chk("rst_done1", 32'(a_s1_done), 32'h0);
    a_rstn = 1'b1; b_rstn = 1'b1;

    // Single read, latency 1: C0 request, C1 issue, C3 done
    a_r0_addr = 32'h4; a_r0_count = `MEM_COUNT_WORD; a_r0_wr = 1'b0;
    a_p_rdat = 32'hDEADBEEF; a_p_code = `MEM_CODE_READ;
    tick();
    chk("rd_issue_count", 32'(a_m_count), 32'(`MEM_COUNT_WORD));
    chk("rd_issue_addr", a_m_addr, 32'h4);
    tick();
    chk("rd_wait_count", 32'(a_m_count), 32'(`MEM_COUNT_NONE));
    chk("rd_wait_done0", 32'(a_s0_done), 32'h0);
    tick();
    chk("rd_done0", 32'(a_s0_done), 32'h1);
    chk("rd_data0", a_s0_rdat, 32'hDEADBEEF);
    chk("rd_code0", 32'(a_s0_code), 32'(`MEM_CODE_READ));
    chk("rd_done1", 32'(a_s1_done), 32'h0);
    chk("rd_res1_code", 32'(a_s1_code), 32'(`MEM_CODE_INVALID));
    chk("rd_res1_data", a_s1_rdat, 32'h0);
    a_r0_count = `MEM_COUNT_NONE;
    tick();
    chk("rd_after_done0", 32'(a_s0_done), 32'h0);
    chk("rd_after_count", 32'(a_m_count), 32'(`MEM_COUNT_NONE));

    // Simultaneous requests out of reset, then continuous alternation
    a_rstn = 1'b0;
    tick();
    a_rstn = 1'b1;
    a_r0_addr = 32'h0; a_r0_count = `MEM_COUNT_WORD; a_r0_wr = 1'b0;
    a_r1_addr = 32'h8; a_r1_count = `MEM_COUNT_WORD; a_r1_wr = 1'b1; a_r1_wdat = 32'h1234;
    a_p_rdat = 32'hA0; a_p_code = `MEM_CODE_READ;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rr%0d_addr", k), a_m_addr, (k % 2 == 1) ? 32'h8 : 32'h0);
      chk($sformatf("rr%0d_wr", k), 32'(a_m_wr), (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k % 2 == 1) chk($sformatf("rr%0d_wdat", k), a_m_wdat, 32'h1234);
      tick(); tick();
      chk($sformatf("rr%0d_done0", k), 32'(a_s0_done), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk($sformatf("rr%0d_done1", k), 32'(a_s1_done), (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k == 3) begin
        a_r0_count = `MEM_COUNT_NONE;
        a_r1_count = `MEM_COUNT_NONE;
      end
      tick();
    end
    chk("rr_res1_data", a_s1_rdat, 32'hA0);

    // Misaligned passthrough on requester 1
    a_r1_addr = 32'h3; a_r1_count = `MEM_COUNT_HALF; a_r1_wr = 1'b0;
    a_p_rdat = 32'h0; a_p_code = `MEM_CODE_MISALIGNED;
    tick();
    chk("mis_count", 32'(a_m_count), 32'(`MEM_COUNT_HALF));
    chk("mis_addr", a_m_addr, 32'h3);
    tick();
    chk("mis_pre_done1", 32'(a_s1_done), 32'h0);
    tick();
    chk("mis_done1", 32'(a_s1_done), 32'h1);
    chk("mis_code1", 32'(a_s1_code), 32'(`MEM_CODE_MISALIGNED));
    chk("mis_data1", a_s1_rdat, 32'h0);
    chk("mis_res0_data", a_s0_rdat, 32'hA0);
    a_r1_count = `MEM_COUNT_NONE;
    tick();
    chk("mis_post_done1", 32'(a_s1_done), 32'h0);

    // Reset during WAIT
    a_r1_addr = 32'h10; a_r1_count = `MEM_COUNT_WORD; a_r1_wr = 1'b1; a_r1_wdat = 32'h77;
    a_p_rdat = 32'h55; a_p_code = `MEM_CODE_WRITE;
    tick(); tick();
    #2;
    a_rstn = 1'b0;
    #1;
    chk("mrst_res1_code", 32'(a_s1_code), 32'(`MEM_CODE_INVALID));
    chk("mrst_res1_data", a_s1_rdat, 32'h0);
    chk("mrst_addr", a_m_addr, 32'h0);
    chk("mrst_wdat", a_m_wdat, 32'h0);
    chk("mrst_count", 32'(a_m_count), 32'(`MEM_COUNT_NONE));
    tick();
    chk("mrst_no_done1", 32'(a_s1_done), 32'h0);
    a_rstn = 1'b1;
    tick();
    chk("mrst_rel_addr", a_m_addr, 32'h10);
    chk("mrst_rel_count", 32'(a_m_count), 32'(`MEM_COUNT_WORD));
    tick(); tick();
    chk("mrst_rel_done1", 32'(a_s1_done), 32'h1);
    chk("mrst_rel_code1", 32'(a_s1_code), 32'(`MEM_CODE_WRITE));
    a_r1_count = `MEM_COUNT_NONE;
    tick();

    // Back-to-back from requester 0 with a new address in the done cycle
    a_r0_addr = 32'h8; a_r0_count = `MEM_COUNT_WORD; a_r0_wr = 1'b0;
    a_p_rdat = 32'h11; a_p_code = `MEM_CODE_READ;
    tick(); tick(); tick();
    chk("b2b_done0_a", 32'(a_s0_done), 32'h1);
    a_r0_addr = 32'hC;
    a_p_rdat = 32'h22;
    tick();
    chk("b2b_idle_count", 32'(a_m_count), 32'(`MEM_COUNT_NONE));
    tick();
    chk("b2b_issue_count", 32'(a_m_count), 32'(`MEM_COUNT_WORD));
    chk("b2b_issue_addr", a_m_addr, 32'hC);
    tick(); tick();
    chk("b2b_done0_b", 32'(a_s0_done), 32'h1);
    chk("b2b_data0_b", a_s0_rdat, 32'h22);
    a_r0_count = `MEM_COUNT_NONE;
    tick();

    // Latency 3 on instance b: capture at end of C4, done at C5
    b_r0_addr = 32'h20; b_r0_count = `MEM_COUNT_WORD; b_r0_wr = 1'b0;
    b_p_rdat = 32'h111; b_p_code = `MEM_CODE_READ;
    tick();
    chk("l3_issue_count", 32'(b_m_count), 32'(`MEM_COUNT_WORD));
    chk("l3_issue_addr", b_m_addr, 32'h20);
    tick();
    chk("l3_wait_count", 32'(b_m_count), 32'(`MEM_COUNT_NONE));
    tick();
    chk("l3_c3_done0", 32'(b_s0_done), 32'h0);
    tick();
    chk("l3_c4_done0", 32'(b_s0_done), 32'h0);
    b_p_rdat = 32'hCAFEF00D;
    tick();
    chk("l3_done0", 32'(b_s0_done), 32'h1);
    chk("l3_data0", b_s0_rdat, 32'hCAFEF00D);
    chk("l3_code0", 32'(b_s0_code), 32'(`MEM_CODE_READ));
    chk("l3_done1", 32'(b_s1_done), 32'h0);
    b_r0_count = `MEM_COUNT_NONE;
    tick();
    chk("l3_post_done0", 32'(b_s0_done), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
